wb_sharedbus: RTL and testbench
===============================

# wb_sharedbus

Parametrised Wishbone shared-bus interconnect: NUM_M masters, NUM_S slaves, one transaction path at a time. Generalises the fixed 8x8 conbus used in the SoC top levels. Adds packed base/mask decode, round-robin arbitration, an internal default slave for unmapped addresses and a bus-timeout error. Instantiated in the system top between lm32 I/D ports (plus optional DMA masters) and the peripherals.

## Interface
- NUM_M, 2, master count (1..8)
- NUM_S, 4, slave count (1..8)
- SLV_BASE, 0, packed NUM_S*32 bits; slave k base at [32k+31:32k]
- SLV_MASK, 0, packed NUM_S*32 bits; slave k matches when (adr & mask_k) == base_k
- TIMEOUT, 255, stalled-strobe cycles before forced err; 0 disables
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low; one clock, all state on rising edge of clk
- m_adr_i  in  NUM_M*32  master addresses, packed
- m_dat_i  in  NUM_M*32  master write data
- m_sel_i  in  NUM_M*4  byte selects
- m_we_i, m_cyc_i, m_stb_i  in  NUM_M each  per-master controls
- m_dat_o  out  32  read data, broadcast to all masters
- m_ack_o, m_err_o, m_rty_o  out  NUM_M each  per-master termination
- s_adr_o  out  32, s_dat_o  out  32, s_sel_o  out  4, s_we_o  out  1  shared slave bus
- s_cyc_o, s_stb_o  out  NUM_S each  per-slave select
- s_dat_i  in  NUM_S*32; s_ack_i, s_err_i, s_rty_i  in  NUM_S each
- grant_o  out  NUM_M  one-hot current owner (debug)

## Operation
- States: IDLE (no owner), OWNED (grant_o one-hot).
- Round-robin pointer last (index of most recent owner); reset value NUM_M-1 so master 0 wins first.
- IDLE: any m_cyc_i high -> next edge grant first requester searching from (last+1) mod NUM_M upward, state OWNED, last := winner.
- OWNED: owner keeps bus while its m_cyc_i high. Owner cyc low at an edge -> if other requests pending, grant next round-robin requester on that same edge (no idle cycle); else IDLE, grant_o = 0.
- Requests from non-owners ignored (no termination) until granted.
- Shared outputs combinationally muxed from owner; all zero when no owner.
- Decode: lowest-index slave whose masked address matches; s_cyc_o[k] = owner cyc & hit_k, s_stb_o[k] = owner stb & hit_k.
- No match: default slave; registered err_d <= owner stb & cyc & nomatch & ~err_d; err_d drives owner m_err_o.
- Termination routing: selected slave ack/err/rty gated with owner m_stb_i -> owner's m_ack_o/m_err_o/m_rty_o only; m_dat_o = selected s_dat_i (0 on no match).
- Timeout (TIMEOUT>0): counter clears on no owner, stb low, or any termination; increments while owner stb high and no termination; at count == TIMEOUT-1, registered err to owner next cycle, counter clears.
- Reset (reset_n low at an edge): state IDLE, grant_o 0, last NUM_M-1, counter 0, err_d 0; all outputs 0 next cycle, including mid-transaction.

## Timing
- Grant latency: 1 cycle from m_cyc_i rise (IDLE) to grant_o/s_cyc_o.
- Slave ack/err/rty -> master: 0 cycles (combinational).
- Default-slave err: 1 cycle after strobe seen; held strobe yields err every second cycle.
- Timeout err: asserted TIMEOUT cycles after first unterminated stb cycle, for 1 cycle.
- Handover: owner cyc low on cycle N -> new owner driven cycle N+1.
- Simultaneous slave termination and timeout expiry: slave termination wins, counter clears, no err.

## Test plan
- NUM_M=2, slave1 base 0x40000000 mask 0xF0000000: m0 reads 0x40000010, slave acks with 0xDEADBEEF same cycle -> grant_o=01 one cycle after cyc, m_ack_o=01, m_dat_o=0xDEADBEEF.
- m0 and m1 raise cyc same cycle after reset -> m0 granted; m0 drops cyc -> grant_o=10 next cycle; both request again after m1 done -> m0 (round-robin).
- m0 strobes 0x90000000 (unmapped) -> m_err_o[0] one cycle later, no s_cyc_o asserted.
- TIMEOUT=8, slave never acks -> m_err_o[0] on 8th cycle after stb, single pulse.
- Overlapping slaves 0 and 2 both matching -> only s_stb_o[0] asserted.
- reset_n low during OWNED transaction -> next cycle grant_o=0, all s_cyc_o/m_ack_o 0; after release m0 wins first.

Source files
------------

// File: rtl/wb_sharedbus.sv
// Wishbone shared-bus interconnect: NUM_M masters share one path to NUM_S slaves.
// Round-robin arbitration, base/mask decode, default-slave error and stall timeout.
module wb_sharedbus #(
  parameter int                  NUM_M    = 2,
  parameter int                  NUM_S    = 4,
  parameter logic [NUM_S*32-1:0] SLV_BASE = '0,
  parameter logic [NUM_S*32-1:0] SLV_MASK = '0,
  parameter int                  TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_M*32-1:0]   m_adr_i,
  input  logic [NUM_M*32-1:0]   m_dat_i,
  input  logic [NUM_M*4-1:0]    m_sel_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  output logic [31:0]           m_dat_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic [NUM_M-1:0]      m_rty_o,
  output logic [31:0]           s_adr_o,
  output logic [31:0]           s_dat_o,
  output logic [3:0]            s_sel_o,
  output logic                  s_we_o,
  output logic [NUM_S-1:0]      s_cyc_o,
  output logic [NUM_S-1:0]      s_stb_o,
  input  logic [NUM_S*32-1:0]   s_dat_i,
  input  logic [NUM_S-1:0]      s_ack_i,
  input  logic [NUM_S-1:0]      s_err_i,
  input  logic [NUM_S-1:0]      s_rty_i,
  output logic [NUM_M-1:0]      grant_o
);

  localparam int LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

  state_t           state_reg;
  logic [NUM_M-1:0] grant_reg;
  logic [LW-1:0]    last_reg;
  logic             err_d_reg;
  logic             tmo_err_reg;

  logic             owned;
  logic             own_cyc;
  logic             own_stb;
  logic             own_busy;
  logic [31:0]      own_adr;
  logic [NUM_S-1:0] hit;
  logic [NUM_S-1:0] sel_oh;
  logic             nomatch;
  logic [31:0]      sel_dat;
  logic             own_ack;
  logic             own_err;
  logic             own_rty;
  logic             own_term;
  logic             rr_found;
  logic [LW-1:0]    rr_idx;

  // The current owner is always the most recent winner, so last_reg doubles as the mux select.
  assign owned    = (state_reg == OWNED);
  assign own_cyc  = owned & m_cyc_i[last_reg];
  assign own_stb  = owned & m_stb_i[last_reg];
  assign own_busy = own_cyc & own_stb;
  assign own_adr  = owned ? m_adr_i[last_reg*32 +: 32] : '0;

  assign s_adr_o  = own_adr;
  assign s_dat_o  = owned ? m_dat_i[last_reg*32 +: 32] : '0;
  assign s_sel_o  = owned ? m_sel_i[last_reg*4 +: 4] : '0;
  assign s_we_o   = owned & m_we_i[last_reg];
  assign grant_o  = grant_reg;

  generate
    for (genvar gi = 0; gi < NUM_S; gi++) begin : g_decode
      assign hit[gi] = ((own_adr & SLV_MASK[gi*32 +: 32]) == SLV_BASE[gi*32 +: 32]);
    end
  endgenerate

  // Isolate the lowest set bit so overlapping windows resolve to the lowest slave index.
  assign sel_oh  = hit & (~hit + NUM_S'(1));
  assign nomatch = ~|hit;

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_S; k++) begin
      if (sel_oh[k]) sel_dat = s_dat_i[k*32 +: 32];
    end
  end

  assign s_cyc_o  = {NUM_S{own_cyc}} & sel_oh;
  assign s_stb_o  = {NUM_S{own_stb}} & sel_oh;
  assign m_dat_o  = owned ? sel_dat : '0;

  assign own_ack  = own_stb & |(sel_oh & s_ack_i);
  assign own_rty  = own_stb & |(sel_oh & s_rty_i);
  assign own_err  = (own_stb & |(sel_oh & s_err_i)) | err_d_reg | tmo_err_reg;
  assign own_term = own_ack | own_err | own_rty;

  assign m_ack_o  = {NUM_M{own_ack}} & grant_reg;
  assign m_err_o  = {NUM_M{own_err}} & grant_reg;
  assign m_rty_o  = {NUM_M{own_rty}} & grant_reg;

  // Search starts just past the previous owner, giving round-robin fairness.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_reg;
    for (int i = 1; i <= NUM_M; i++) begin
      if (!rr_found && m_cyc_i[(int'(last_reg) + i) % NUM_M]) begin
        rr_found = 1'b1;
        rr_idx   = LW'((int'(last_reg) + i) % NUM_M);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= LW'(NUM_M - 1);
      err_d_reg <= 1'b0;
    end else begin
      // Default slave answers every other cycle of a held strobe.
      err_d_reg <= own_busy & nomatch & ~err_d_reg;
      case (state_reg)
        IDLE: begin
          if (rr_found) begin
            state_reg <= OWNED;
            grant_reg <= NUM_M'(1) << rr_idx;
            last_reg  <= rr_idx;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            if (rr_found) begin
              grant_reg <= NUM_M'(1) << rr_idx;
              last_reg  <= rr_idx;
            end else begin
              state_reg <= IDLE;
              grant_reg <= '0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      logic [CW-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt_reg     <= '0;
          tmo_err_reg <= 1'b0;
        end else begin
          tmo_err_reg <= 1'b0;
          if (!own_busy || own_term) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            cnt_reg     <= '0;
            tmo_err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
      end
    end else begin : g_no_timeout
      assign tmo_err_reg = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_sharedbus.sv
// Randomised bench for wb_sharedbus against a per-cycle behavioural model of the bus rules,
// preceded by directed scenarios for arbitration, decode, default slave, timeout and reset.
module tb_wb_sharedbus;

  localparam int NM  = 2;
  localparam int NS  = 4;
  localparam int TMO = 8;
  // slave0 0x0xxxxxxx, slave1 0x4xxxxxxx, slave2 0x0-0x3xxxxxxx (overlaps slave0), slave3 0x8xxxxxxx
  localparam logic [NS*32-1:0] BASE = {32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hF000_0000, 32'hC000_0000, 32'hF000_0000, 32'hF000_0000};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM*32-1:0]  m_adr_i, m_dat_i;
  logic [NM*4-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i, m_cyc_i, m_stb_i;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic [NS*32-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;
  logic [NM-1:0]     grant_o;

  wb_sharedbus #(
    .NUM_M(NM), .NUM_S(NS), .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] base_tab[NS] = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000};
  logic [31:0] mask_tab[NS] = '{32'hF000_0000, 32'hF000_0000, 32'hC000_0000, 32'hF000_0000};
  logic [31:0] adr_tab[8]   = '{32'h4000_0010, 32'h0000_0020, 32'h1000_0000, 32'h8000_0004,
                                32'h9000_0000, 32'hC000_0000, 32'h3FFF_FFFC, 32'h4FFF_FFFF};

  // Model state: owner index (-1 = nobody), last winner, stall count, pending error pulses.
  int owner, last, stalled, cur_tgt;
  bit dflt_err, tmo_fire, cur_cyc, cur_stb;
  logic [NM-1:0] e_grant, e_ack, e_err, e_rty;
  logic [NS-1:0] e_scyc, e_sstb;
  logic [31:0]   e_dat, e_adr, e_sdat;
  logic [3:0]    e_sel;
  logic          e_we;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int target_of(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if ((a & mask_tab[k]) == base_tab[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1; last = NM - 1; stalled = 0; dflt_err = 0; tmo_fire = 0;
  endtask

  // Build expected outputs from model state and current inputs, then compare.
  task automatic tick_check();
    @(negedge clk);
    e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0; e_scyc = '0; e_sstb = '0;
    e_dat = '0; e_adr = '0; e_sdat = '0; e_sel = '0; e_we = 1'b0;
    cur_cyc = 0; cur_stb = 0; cur_tgt = -1;
    if (owner >= 0) begin
      cur_cyc = m_cyc_i[owner];
      cur_stb = m_stb_i[owner];
      e_adr   = m_adr_i[owner*32 +: 32];
      cur_tgt = target_of(e_adr);
      e_grant[owner] = 1'b1;
      e_sdat = m_dat_i[owner*32 +: 32];
      e_sel  = m_sel_i[owner*4 +: 4];
      e_we   = m_we_i[owner];
      if (cur_tgt >= 0) begin
        e_scyc[cur_tgt] = cur_cyc;
        e_sstb[cur_tgt] = cur_stb;
        e_dat = s_dat_i[cur_tgt*32 +: 32];
        if (cur_stb) begin
          e_ack[owner] = s_ack_i[cur_tgt];
          e_err[owner] = s_err_i[cur_tgt];
          e_rty[owner] = s_rty_i[cur_tgt];
        end
      end
      if (dflt_err || tmo_fire) e_err[owner] = 1'b1;
      if ((e_ack | e_err | e_rty) != '0)
        $display("txn m%0d adr=%08h %s dat=%08h", owner, e_adr,
                 (e_ack != '0) ? "ack" : ((e_err != '0) ? "err" : "rty"), e_dat);
    end
    check_eq("grant_o", grant_o, e_grant);
    check_eq("s_cyc_o", s_cyc_o, e_scyc);
    check_eq("s_stb_o", s_stb_o, e_sstb);
    check_eq("m_ack_o", m_ack_o, e_ack);
    check_eq("m_err_o", m_err_o, e_err);
    check_eq("m_rty_o", m_rty_o, e_rty);
    check_eq("m_dat_o", m_dat_o, e_dat);
    check_eq("s_adr_o", s_adr_o, e_adr);
    check_eq("s_dat_o", s_dat_o, e_sdat);
    check_eq("s_sel_o", s_sel_o, e_sel);
    check_eq("s_we_o",  s_we_o,  e_we);
  endtask

  // Advance the model across the rising edge using the inputs seen in tick_check.
  task automatic tick_advance();
    bit term, busy, new_dflt, new_fire, found;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      term     = ((e_ack | e_err | e_rty) != '0);
      busy     = (owner >= 0) && cur_cyc && cur_stb;
      new_dflt = busy && (cur_tgt < 0) && !dflt_err;
      new_fire = 0;
      if (busy && !term) begin
        stalled++;
        if (stalled == TMO) begin
          new_fire = 1;
          stalled  = 0;
        end
      end else begin
        stalled = 0;
      end
      dflt_err = new_dflt;
      tmo_fire = new_fire;
      if (owner < 0 || !cur_cyc) begin
        owner = -1;
        found = 0;
        for (int i = 1; i <= NM; i++) begin
          if (!found && m_cyc_i[(last + i) % NM]) begin
            found = 1;
            owner = (last + i) % NM;
          end
        end
        if (found) last = owner;
      end
    end
    #1;
  endtask

  task automatic step();
    tick_check();
    tick_advance();
  endtask

  task automatic clear_inputs();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    s_dat_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    tick_check();
    check_eq("rst_grant", grant_o, 2'b00);
    tick_advance();
    reset_n = 1'b1;

    // Read from slave1 with a same-cycle ack.
    $display("scenario: single read from slave1");
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[31:0] = 32'h4000_0010;
    s_ack_i = 4'b0010; s_dat_i[63:32] = 32'hDEAD_BEEF;
    tick_check();
    check_eq("t1_grant_idle", grant_o, 2'b00);
    tick_advance();
    tick_check();
    check_eq("t1_grant", grant_o, 2'b01);
    check_eq("t1_ack", m_ack_o, 2'b01);
    check_eq("t1_dat", m_dat_o, 32'hDEAD_BEEF);
    check_eq("t1_scyc", s_cyc_o, 4'b0010);
    tick_advance();
    clear_inputs();
    step();

    // Round-robin between two masters.
    $display("scenario: round-robin handover");
    reset_pulse();
    m_cyc_i = 2'b11;
    step();
    tick_check();
    check_eq("t2_first", grant_o, 2'b01);
    tick_advance();
    m_cyc_i = 2'b10;
    tick_check();
    check_eq("t2_hold", grant_o, 2'b01);
    tick_advance();
    tick_check();
    check_eq("t2_handover", grant_o, 2'b10);
    tick_advance();
    m_cyc_i = 2'b00;
    step();
    m_cyc_i = 2'b11;
    step();
    tick_check();
    check_eq("t2_rr_m0", grant_o, 2'b01);
    tick_advance();
    clear_inputs();
    step();

    // Unmapped address hits the default slave.
    $display("scenario: default slave error");
    reset_pulse();
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[31:0] = 32'h9000_0000;
    step();
    tick_check();
    check_eq("t3_noerr", m_err_o, 2'b00);
    check_eq("t3_noscyc", s_cyc_o, 4'b0000);
    tick_advance();
    tick_check();
    check_eq("t3_err", m_err_o, 2'b01);
    tick_advance();
    tick_check();
    check_eq("t3_err_gap", m_err_o, 2'b00);
    tick_advance();
    clear_inputs();
    step();

    // Silent slave: timeout error after TMO stalled cycles, then overlap decode, then reset mid-transfer.
    $display("scenario: timeout, overlap decode, reset while owned");
    reset_pulse();
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_adr_i[31:0] = 32'h8000_0004;
    step();
    for (int i = 0; i < 10; i++) begin
      tick_check();
      check_eq("t4_tmo", m_err_o, (i == TMO) ? 2'b01 : 2'b00);
      tick_advance();
    end
    m_adr_i[31:0] = 32'h0000_0020;
    tick_check();
    check_eq("t5_overlap_stb", s_stb_o, 4'b0001);
    check_eq("t5_overlap_cyc", s_cyc_o, 4'b0001);
    tick_advance();
    s_ack_i = 4'b0001;
    reset_n = 1'b0;
    tick_check();
    check_eq("t6_ack_before", m_ack_o, 2'b01);
    tick_advance();
    reset_n = 1'b1;
    m_cyc_i = 2'b11;
    tick_check();
    check_eq("t6_grant0", grant_o, 2'b00);
    check_eq("t6_scyc0", s_cyc_o, 4'b0000);
    check_eq("t6_ack0", m_ack_o, 2'b00);
    tick_advance();
    tick_check();
    check_eq("t6_m0_first", grant_o, 2'b01);
    tick_advance();
    clear_inputs();
    step();

    // Randomised traffic.
    $display("scenario: random traffic");
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < NM; m++) begin
        if ($urandom_range(0, 7) == 0) m_cyc_i[m] = ~m_cyc_i[m];
        m_stb_i[m] = m_cyc_i[m] & ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) m_adr_i[m*32 +: 32] = adr_tab[$urandom_range(0, 7)];
        m_dat_i[m*32 +: 32] = $urandom;
        m_sel_i[m*4 +: 4]   = 4'($urandom);
        m_we_i[m]           = 1'($urandom);
      end
      for (int k = 0; k < NS; k++) begin
        s_ack_i[k] = ($urandom_range(0, 3) == 0);
        s_err_i[k] = ($urandom_range(0, 15) == 0);
        s_rty_i[k] = ($urandom_range(0, 15) == 0);
        s_dat_i[k*32 +: 32] = $urandom;
      end
      reset_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
